// File: rtl/cpu_pkg.sv
// Shared types and helpers for the memory port arbiter.
package cpu_pkg;

    typedef enum logic {
        IDLE,
        WORD2
    } arb_state_t;

    // Owner of the beat issued in the previous cycle, used to route i_mem_do.
    typedef enum logic [1:0] {
        NONE,
        IF,
        D_HALF,
        D_WORD
    } ret_tag_t;

    localparam logic SZ_HALF = 1'b0;
    localparam logic SZ_WORD = 1'b1;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(logic size, logic [1:0] addr_lsb);
        return (size == SZ_WORD) ? (addr_lsb != 2'b00) : addr_lsb[0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the requesters (fetch, load/store), the arbiter and the memory macro.
// master = requesters plus memory macro, slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 13
);
    // Instruction fetch
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [0:1][7:0]       if_rdata;

    // Load/store unit
    logic                  d_req;
    logic                  d_we;
    logic                  d_size;
    logic [0:1]            d_be;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [0:3][7:0]       d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [0:3][7:0]       d_rdata;
    logic                  d_err;

    // Memory macro
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [0:1][7:0]       mem_di;
    logic                  mem_en;
    logic                  mem_rd_en;
    logic [0:1]            mem_wr_en;
    logic [0:1][7:0]       mem_do;

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_be, d_addr, d_wdata, mem_do,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_addr, mem_di, mem_en, mem_rd_en, mem_wr_en
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_be, d_addr, d_wdata, mem_do,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_addr, mem_di, mem_en, mem_rd_en, mem_wr_en
    );

endinterface

// File: rtl/mem_arb_starve.sv
// Saturating count of consecutive denied fetch cycles; raises fetch priority at the limit.
module mem_arb_starve #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_req_i,
    input  logic if_gnt_i,
    output logic fetch_prio_o
);

    localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Clear on fetch grant, otherwise count pending-but-denied cycles up to the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt_i) begin
            cnt_d = '0;
        end else if (if_req_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_prio_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the halfword memory port between instruction fetch and the load/store unit.
// Words are issued as two big-endian halfword beats; data has priority over fetch
// until fetch has been denied STARVE_LIMIT cycles in a row.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_DEPTH    = 2**12,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH * 2);

    arb_state_t            state_q, state_d;
    ret_tag_t              tag_q, tag_d;
    logic                  ret_err_q, ret_err_d;
    logic                  ret_we_q, ret_we_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic                  lat_we_q, lat_we_d;
    logic [15:0]           lat_lo_q, lat_lo_d;
    logic [15:0]           hi_q, hi_d;

    logic                  fetch_prio;
    logic                  d_pick;
    logic                  if_gnt;
    logic                  d_gnt;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_di;
    logic                  mem_en;
    logic                  mem_rd_en;
    logic [0:1]            mem_wr_en;
    logic [31:0]           d_rdata;

    mem_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk_i       (clk),
        .rst_ni      (rst),
        .if_req_i    (bus.if_req),
        .if_gnt_i    (if_gnt),
        .fetch_prio_o(fetch_prio)
    );

    // Data wins a tie unless fetch has starved long enough.
    assign d_pick = bus.d_req && !(bus.if_req && fetch_prio);

    // Arbitration, beat issue and next-state logic.
    always_comb begin
        state_d    = state_q;
        tag_d      = NONE;
        ret_err_d  = 1'b0;
        ret_we_d   = 1'b0;
        lat_addr_d = lat_addr_q;
        lat_we_d   = lat_we_q;
        lat_lo_d   = lat_lo_q;
        hi_d       = hi_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_addr   = '0;
        mem_di     = '0;
        mem_en     = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 2'b00;

        unique case (state_q)
            IDLE: begin
                // Grants are held off while reset is asserted so every output reads 0.
                if (rst && d_pick) begin
                    d_gnt    = 1'b1;
                    ret_we_d = bus.d_we;
                    if (is_misaligned(bus.d_size, bus.d_addr[1:0])) begin
                        tag_d     = D_HALF;
                        ret_err_d = 1'b1;
                    end else if (bus.d_size == SZ_HALF) begin
                        tag_d     = D_HALF;
                        mem_en    = 1'b1;
                        mem_addr  = bus.d_addr;
                        mem_rd_en = !bus.d_we;
                        if (bus.d_we) begin
                            mem_wr_en = bus.d_be;
                            mem_di    = bus.d_wdata[2:3];
                        end
                    end else begin
                        // Beat 0 carries bytes 0..1; the low half is replayed from latches.
                        mem_en     = 1'b1;
                        mem_addr   = bus.d_addr;
                        mem_rd_en  = !bus.d_we;
                        if (bus.d_we) begin
                            mem_wr_en = 2'b11;
                            mem_di    = bus.d_wdata[0:1];
                        end
                        lat_addr_d = bus.d_addr + ADDR_WIDTH'(2);
                        lat_we_d   = bus.d_we;
                        lat_lo_d   = bus.d_wdata[2:3];
                        state_d    = WORD2;
                    end
                end else if (rst && bus.if_req) begin
                    if_gnt    = 1'b1;
                    tag_d     = IF;
                    mem_en    = 1'b1;
                    mem_rd_en = 1'b1;
                    mem_addr  = bus.if_addr;
                end
            end
            WORD2: begin
                mem_en    = 1'b1;
                mem_addr  = lat_addr_q;
                mem_rd_en = !lat_we_q;
                if (lat_we_q) begin
                    mem_wr_en = 2'b11;
                    mem_di    = lat_lo_q;
                end
                hi_d     = bus.mem_do;
                tag_d    = D_WORD;
                ret_we_d = lat_we_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, return tag and word latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tag_q      <= NONE;
            ret_err_q  <= 1'b0;
            ret_we_q   <= 1'b0;
            lat_addr_q <= '0;
            lat_we_q   <= 1'b0;
            lat_lo_q   <= '0;
            hi_q       <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            ret_err_q  <= ret_err_d;
            ret_we_q   <= ret_we_d;
            lat_addr_q <= lat_addr_d;
            lat_we_q   <= lat_we_d;
            lat_lo_q   <= lat_lo_d;
            hi_q       <= hi_d;
        end
    end

    // Route returning memory data to its owner; writes and errors return zero.
    always_comb begin
        d_rdata = '0;
        if (!ret_err_q && !ret_we_q) begin
            if (tag_q == D_HALF) begin
                d_rdata = {16'h0000, bus.mem_do};
            end else if (tag_q == D_WORD) begin
                d_rdata = {hi_q, bus.mem_do};
            end
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.if_rvalid = (tag_q == IF);
    assign bus.if_rdata  = (tag_q == IF) ? bus.mem_do : '0;
    assign bus.d_gnt     = d_gnt;
    assign bus.d_rvalid  = (tag_q == D_HALF) || (tag_q == D_WORD);
    assign bus.d_rdata   = d_rdata;
    assign bus.d_err     = (tag_q == D_HALF) && ret_err_q;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_di    = mem_di;
    assign bus.mem_en    = mem_en;
    assign bus.mem_rd_en = mem_rd_en;
    assign bus.mem_wr_en = mem_wr_en;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses computed from a
// byte-array reference memory at grant time, monitors pop and compare on rvalid.
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    localparam int unsigned AW    = 13;
    localparam int          LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(
        .MEM_DEPTH   (4096),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Memory macro stub and reference byte memory.
    logic [7:0]  ref_mem [0:8191];
    logic [15:0] mem     [0:4095];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_rd_en) bus.mem_do <= mem[bus.mem_addr[AW-1:1]];
            if (bus.mem_wr_en[0]) mem[bus.mem_addr[AW-1:1]][15:8] <= bus.mem_di[0];
            if (bus.mem_wr_en[1]) mem[bus.mem_addr[AW-1:1]][7:0] <= bus.mem_di[1];
        end
    end

    task automatic set_half(input int a, input logic [15:0] v);
        ref_mem[a]     = v[15:8];
        ref_mem[a + 1] = v[7:0];
        mem[a / 2]     = v;
    endtask

    typedef struct {
        logic        chk_data;
        logic        err;
        logic [31:0] data;
        int          due;
    } d_exp_t;

    typedef struct {
        logic [15:0] data;
        int          due;
    } f_exp_t;

    d_exp_t d_q[$];
    f_exp_t f_q[$];

    // Reference semantics of one data transaction, applied at its grant.
    function automatic d_exp_t ref_data(input logic we, input logic size, input logic [0:1] be,
                                        input int a, input logic [31:0] wd);
        d_exp_t e;
        e.err      = size ? ((a % 4) != 0) : ((a % 2) != 0);
        e.chk_data = !we || e.err;
        e.data     = 32'h0;
        e.due      = 0;
        if (!e.err) begin
            if (size) begin
                if (we) begin
                    ref_mem[a]     = wd[31:24];
                    ref_mem[a + 1] = wd[23:16];
                    ref_mem[a + 2] = wd[15:8];
                    ref_mem[a + 3] = wd[7:0];
                end else begin
                    e.data = {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
                end
            end else if (we) begin
                if (be[0]) ref_mem[a] = wd[15:8];
                if (be[1]) ref_mem[a + 1] = wd[7:0];
            end else begin
                e.data = {16'h0000, ref_mem[a], ref_mem[a + 1]};
            end
        end
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
    task automatic d_op(input logic we, input logic size, input logic [0:1] be, input int a,
                        input logic [31:0] wd, output int lat);
        d_exp_t e;
        logic   got;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_size  = size;
        bus.d_be    = be;
        bus.d_addr  = AW'(a);
        bus.d_wdata = wd;
        lat = 0;
        got = 1'b0;
        while (!got && lat <= 60) begin
            @(negedge clk);
            if (bus.d_gnt) begin
                got = 1'b1;
            end else begin
                lat++;
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            note_fail("d_gnt timeout");
        end else begin
            e     = ref_data(we, size, be, a, wd);
            e.due = cyc + ((size && !e.err) ? 2 : 1);
            d_q.push_back(e);
            @(posedge clk);
            #1;
        end
        bus.d_req = 1'b0;
    endtask

    task automatic f_op(input int a, output int lat);
        f_exp_t e;
        logic   got;
        bus.if_req  = 1'b1;
        bus.if_addr = AW'(a);
        lat = 0;
        got = 1'b0;
        while (!got && lat <= 60) begin
            @(negedge clk);
            if (bus.if_gnt) begin
                got = 1'b1;
            end else begin
                lat++;
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            note_fail("if_gnt timeout");
        end else begin
            e.data = {ref_mem[a], ref_mem[a + 1]};
            e.due  = cyc + 1;
            f_q.push_back(e);
            @(posedge clk);
            #1;
        end
        bus.if_req = 1'b0;
    endtask

    // Response monitor.
    initial begin
        d_exp_t de;
        f_exp_t fe;
        forever begin
            @(negedge clk);
            if (bus.if_rvalid) begin
                if (f_q.size() == 0) begin
                    note_fail("if_rvalid unexpected");
                end else begin
                    fe = f_q.pop_front();
                    check("if_rdata", bus.if_rdata, fe.data);
                    check("if_rvalid cycle", cyc, fe.due);
                end
            end
            if (bus.d_rvalid) begin
                if (d_q.size() == 0) begin
                    note_fail("d_rvalid unexpected");
                end else begin
                    de = d_q.pop_front();
                    check("d_err", bus.d_err, de.err);
                    check("d_rvalid cycle", cyc, de.due);
                    if (de.chk_data) check("d_rdata", bus.d_rdata, de.data);
                end
            end
        end
    end

    // Arbitration and strobe monitor derived from the priority and starvation rules.
    initial begin
        int   starve;
        logic word2, eif, ed, al, emem;
        logic [1:0] ewr;
        starve = 0;
        word2  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                starve = 0;
                word2  = 1'b0;
            end else begin
                eif  = bus.if_req && !word2 && (!bus.d_req || starve == LIMIT);
                ed   = bus.d_req && !word2 && !(bus.if_req && starve == LIMIT);
                al   = bus.d_size ? (bus.d_addr[1:0] == 2'b00) : !bus.d_addr[0];
                emem = word2 || eif || (ed && al);
                if (bus.if_req || bus.d_req || word2) begin
                    check("gnt/mem_en", {bus.if_gnt, bus.d_gnt, bus.mem_en}, {eif, ed, emem});
                end else begin
                    check("idle strobes", {bus.mem_en, bus.mem_rd_en, bus.mem_wr_en}, 4'b0);
                end
                if (eif) begin
                    check("fetch beat", {bus.mem_addr, bus.mem_rd_en, bus.mem_wr_en},
                          {bus.if_addr, 1'b1, 2'b00});
                end
                if (ed && al) begin
                    ewr = !bus.d_we ? 2'b00 : (bus.d_size ? 2'b11 : bus.d_be);
                    check("data beat", {bus.mem_addr, bus.mem_rd_en, bus.mem_wr_en},
                          {bus.d_addr, !bus.d_we, ewr});
                    if (bus.d_we) begin
                        check("data di", bus.mem_di,
                              bus.d_size ? bus.d_wdata[0:1] : bus.d_wdata[2:3]);
                    end
                end
                starve = eif ? 0 : ((bus.if_req && starve < LIMIT) ? starve + 1 : starve);
                word2  = ed && bus.d_size && al;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "simulation timeout");
    end

    initial begin
        int ld, lf, nrv;
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) mem[i] = {ref_mem[2 * i], ref_mem[2 * i + 1]};
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 1'b0; bus.d_be = 2'b00;
        bus.d_addr = '0; bus.d_wdata = '0;
        #1;
        check("reset fetch/data outs",
              {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_err}, 0);
        check("reset mem outs",
              {bus.mem_addr, bus.mem_di, bus.mem_en, bus.mem_rd_en, bus.mem_wr_en}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Fetch only.
        set_half('h10, 16'hABCD);
        f_op('h10, lf);
        check("t1 fetch gnt latency", lf, 0);
        repeat (2) begin @(posedge clk); #1; end

        // Simultaneous fetch and data halfword read: data first.
        set_half('h20, 16'h1234);
        fork
            f_op('h10, lf);
            d_op(1'b0, SZ_HALF, 2'b00, 'h20, 32'h0, ld);
        join
        check("t2 data gnt latency", ld, 0);
        check("t2 fetch gnt latency", lf, 1);
        repeat (2) begin @(posedge clk); #1; end

        // Word write beats, then word read with a blocked fetch.
        fork
            d_op(1'b1, SZ_WORD, 2'b00, 'h40, 32'hDEADBEEF, ld);
            begin
                @(negedge clk);
                check("t3 beat0", {bus.mem_en, bus.mem_addr, bus.mem_di, bus.mem_wr_en},
                      {1'b1, 13'h40, 16'hDEAD, 2'b11});
                @(negedge clk);
                check("t3 beat1", {bus.mem_en, bus.mem_addr, bus.mem_di, bus.mem_wr_en},
                      {1'b1, 13'h42, 16'hBEEF, 2'b11});
            end
        join
        fork
            d_op(1'b0, SZ_WORD, 2'b00, 'h40, 32'h0, ld);
            f_op('h10, lf);
        join
        check("t3 fetch blocked in WORD2", lf, 2);
        repeat (3) begin @(posedge clk); #1; end

        // Starvation limit.
        fork
            f_op('h12, lf);
            for (int k = 0; k < 6; k++) d_op(1'b0, SZ_HALF, 2'b00, 'h20 + 2 * k, 32'h0, ld);
        join
        check("t4 fetch starvation latency", lf, LIMIT);
        repeat (2) begin @(posedge clk); #1; end

        // Misalignment.
        d_op(1'b0, SZ_HALF, 2'b00, 'h21, 32'h0, ld);
        d_op(1'b0, SZ_WORD, 2'b00, 'h42, 32'h0, ld);
        d_op(1'b1, SZ_HALF, 2'b11, 'h23, 32'h00005A5A, ld);
        d_op(1'b0, SZ_HALF, 2'b00, 'h22, 32'h0, ld);
        repeat (2) begin @(posedge clk); #1; end

        // Reset while in WORD2.
        d_op(1'b0, SZ_WORD, 2'b00, 'h40, 32'h0, ld);
        #2;
        bus.if_req  = 1'b1;
        bus.if_addr = AW'('h10);
        rst         = 1'b0;
        d_q.delete();
        #1;
        check("t6 reset fetch/data outs",
              {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_err}, 0);
        check("t6 reset d_rdata", bus.d_rdata, 0);
        check("t6 reset mem outs",
              {bus.mem_addr, bus.mem_di, bus.mem_en, bus.mem_rd_en, bus.mem_wr_en}, 0);
        @(posedge clk);
        #1 bus.if_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        nrv = 0;
        repeat (4) begin
            @(negedge clk);
            nrv += int'(bus.d_rvalid) + int'(bus.if_rvalid);
        end
        check("t6 no rvalid after reset", nrv, 0);
        @(posedge clk);
        #1;
        d_op(1'b0, SZ_HALF, 2'b00, 'h40, 32'h0, ld);
        check("t6 post-reset gnt latency", ld, 0);
        repeat (2) begin @(posedge clk); #1; end

        // Randomized mixed traffic in a small window so reads hit earlier writes.
        fork
            for (int k = 0; k < 150; k++) begin
                logic       we_r, sz_r;
                logic [0:1] be_r;
                int         a, lr;
                we_r = 1'($urandom_range(0, 1));
                sz_r = 1'($urandom_range(0, 1));
                be_r = 2'($urandom_range(1, 3));
                a    = $urandom_range(0, 63);
                if ($urandom_range(0, 3) != 0) a = sz_r ? (a & ~3) : (a & ~1);
                d_op(we_r, sz_r, be_r, a, $urandom, lr);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            for (int k = 0; k < 100; k++) begin
                int lr;
                f_op(2 * $urandom_range(0, 31), lr);
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
        join

        repeat (6) begin @(posedge clk); #1; end
        check("d queue drained", d_q.size(), 0);
        check("f queue drained", f_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
